fnd_scan_driver: RTL and testbench
==================================

// Module: fnd_scan_driver
// PURPOSE
//   Time-multiplexed driver for a multi-digit common-cathode/anode FND module.
//   Consumes the 8-bit segment codes produced by the BCD-add/segment-decode
//   stage (one code per digit) and scans them onto a shared segment bus.
//   Each digit is enabled in turn at a fixed rate. New frames are double-buffered
//   and are applied only at a frame boundary, so a partial update never shows.
// PARAMETERS
//   NUM_DIGITS      4     digits scanned; 2..8
//   CLK_DIV         1000  clk cycles per digit slot; >=2
//   SEG_ACTIVE_LOW  0     1: invert fnd_seg (segment on = 0)
// PORTS
//   clk         in   1               system clock, rising edge
//   rst_n       in   1               async reset, active low
//   load        in   1               1-cycle strobe: capture seg_in/blank_mask
//   seg_in      in   8*NUM_DIGITS    segment codes; digit k = [8k+7:8k], 1=on
//   blank_mask  in   NUM_DIGITS      bit k=1: digit k blanked
//   fnd_seg     out  8               shared segment bus (polarity per param)
//   fnd_com     out  NUM_DIGITS      digit enables, one-hot active low
//   pending     out  1               shadow holds data not yet displayed
//   frame_done  out  1               1-cycle pulse when digit NUM_DIGITS-1 slot ends
// BEHAVIOUR
//   - Reset (async assert, sync release): presc=0, idx=0, active/shadow
//     codes=0, masks=0, pending=0, frame_done=0, fnd_com=all 1s,
//     fnd_seg=OFF (8'h00, or 8'hFF if SEG_ACTIVE_LOW).
//   - presc counts 0..CLK_DIV-1; tick = (presc==CLK_DIV-1). On tick: presc<=0,
//     idx<=(idx==NUM_DIGITS-1)?0:idx+1. No other idx changes.
//   - frame_done<=tick && idx==NUM_DIGITS-1 (same edge as idx wraps to 0).
//   - Outputs are registered, 1-cycle latency from idx/active data:
//     fnd_com<=~(1<<idx); fnd_seg<=active_code[idx] (^8'hFF if SEG_ACTIVE_LOW).
//     If active_mask[idx]: fnd_com<=all 1s, fnd_seg<=OFF.
//   - load (non-wrap cycle): shadow<=seg_in,blank_mask; pending<=1.
//     load while pending: newer data overwrites shadow (last load wins).
//   - Frame boundary = tick && idx==NUM_DIGITS-1. If pending: active<=shadow,
//     pending<=0. If load on the same cycle: seg_in/blank_mask go straight
//     to active, shadow also updated, pending<=0 (load is never lost).
//   - The first digit slot of the new frame (idx=0) shows the new data.
//   - Reset mid-frame: all state returns to reset values immediately.
//     Pending data is discarded.
//   - Only fnd_com one-hot low or all-high is ever driven; never two digits on.
// CONFIGURATION
//   FND_DEADTIME_EN defined: during the first clk of every digit slot
//     (presc==0), fnd_com<=all 1s and fnd_seg<=OFF. This suppresses ghosting.
//     The digit is then lit for CLK_DIV-1 cycles.
//   Not defined: the digit is lit for all CLK_DIV cycles of its slot.
//     fnd_com changes directly from one digit to the next.
// TESTING  (NUM_DIGITS=4, CLK_DIV=4, SEG_ACTIVE_LOW=0 unless stated)
//   1 Reset: hold rst_n=0 -> fnd_com=4'b1111, fnd_seg=8'h00, pending=0.
//     Release rst_n -> fnd_com=4'b1110 at the first edge after release.
//     fnd_com then steps 1101,1011,0111 every 4 clks.
//   2 load seg_in=32'h4F5B063F mid-frame -> pending=1 until the boundary.
//     Digits keep showing 8'h00 until the boundary. Next frame: digit0=3F,
//     1=06, 2=5B, 3=4F. frame_done pulses once per 16 clks.
//   3 Two loads in one frame (32'h11111111, then 32'h22222222) -> next
//     frame shows only 22 on every digit.
//   4 load asserted exactly on the boundary cycle with 32'h66666666 ->
//     idx=0 slot shows 66 and pending stays 0.
//   5 blank_mask=4'b1010 -> digits 1,3 slots: fnd_com=1111, fnd_seg=00.
//     SEG_ACTIVE_LOW=1: lit digits show inverted codes; blanked show FF.
//   6 FND_DEADTIME_EN build: each slot starts with 1 clk of fnd_com=1111.
//     rst_n pulsed low mid-slot -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// fnd_scan_driver
//   Time-multiplexed driver for a multi-digit FND (7-seg + dp) module.
//   Per-digit 8-bit segment codes are captured into a shadow buffer on a
//   load strobe. They are copied to the displayed (active) buffer only at a
//   frame boundary, so a partially updated frame is never shown.
//   Digits are enabled one at a time on a shared segment bus.
//
// Parameters
//   NUM_DIGITS      digits scanned (2..8)
//   CLK_DIV         clk cycles per digit slot (>=2)
//   SEG_ACTIVE_LOW  1: segment bus is inverted (segment on = 0)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   load        in   1-cycle strobe capturing seg_in / blank_mask
//   seg_in      in   segment codes, digit k = seg_in[8k+7:8k], 1 = on
//   blank_mask  in   bit k = 1 blanks digit k
//   fnd_seg     out  shared segment bus (registered)
//   fnd_com     out  digit enables, one-hot active low or all high (registered)
//   pending     out  shadow holds data not yet displayed
//   frame_done  out  1-cycle pulse at the end of the last digit slot
//
// Build option
//   FND_DEADTIME_EN  when defined, the first clk of every digit slot is blank
//                    (all digits off) to suppress ghosting between digits.
// -----------------------------------------------------------------------------
module fnd_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [7:0]              fnd_seg,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] COM_OFF    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] COM_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [8*NUM_DIGITS-1:0] active_code_r;
    logic [NUM_DIGITS-1:0]   active_mask_r;
    logic [8*NUM_DIGITS-1:0] shadow_code_r;
    logic [NUM_DIGITS-1:0]   shadow_mask_r;
    logic                    pending_r;
    logic                    frame_done_r;
    logic [7:0]              fnd_seg_r;
    logic [NUM_DIGITS-1:0]   fnd_com_r;

    logic                    tick_s;
    logic                    boundary_s;
    logic                    idx_valid_s;
    logic                    dead_s;
    logic [7:0]              cur_code_s;
    logic                    cur_blank_s;
    logic [7:0]              next_seg_s;
    logic [NUM_DIGITS-1:0]   next_com_s;

    assign tick_s      = (presc_r == PRESC_LAST);
    assign boundary_s  = tick_s && (idx_r == IDX_LAST);
    // An index outside the digit range cannot occur in normal operation; if it
    // ever does (upset), the bus is forced dark rather than reading garbage.
    assign idx_valid_s = (idx_r <= IDX_LAST);
    assign cur_code_s  = active_code_r[{idx_r, 3'b000} +: 8];
    assign cur_blank_s = active_mask_r[idx_r];

`ifdef FND_DEADTIME_EN
    assign dead_s = (presc_r == {PW{1'b0}});
`else
    assign dead_s = 1'b0;
`endif

    // Next value of the registered digit-enable and segment outputs.
    always_comb begin
        next_seg_s = SEG_OFF;
        next_com_s = COM_OFF;
        if (idx_valid_s && !cur_blank_s && !dead_s) begin
            next_seg_s = cur_code_s ^ SEG_OFF;
            next_com_s = ~(COM_ONE << idx_r);
        end else begin
            next_seg_s = SEG_OFF;
            next_com_s = COM_OFF;
        end
    end

    // Slot prescaler and digit index; the index wraps at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r      <= {PW{1'b0}};
            idx_r        <= {IW{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary_s;
            if (tick_s) begin
                presc_r <= {PW{1'b0}};
                idx_r   <= (idx_r >= IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Double buffer: loads land in the shadow, the active copy changes only
    // at a frame boundary. A load on the boundary itself bypasses the shadow
    // so it is displayed immediately and never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_code_r <= {(8*NUM_DIGITS){1'b0}};
            active_mask_r <= {NUM_DIGITS{1'b0}};
            shadow_code_r <= {(8*NUM_DIGITS){1'b0}};
            shadow_mask_r <= {NUM_DIGITS{1'b0}};
            pending_r     <= 1'b0;
        end else begin
            if (load) begin
                shadow_code_r <= seg_in;
                shadow_mask_r <= blank_mask;
            end else begin
                shadow_code_r <= shadow_code_r;
                shadow_mask_r <= shadow_mask_r;
            end

            if (boundary_s) begin
                pending_r <= 1'b0;
                if (load) begin
                    active_code_r <= seg_in;
                    active_mask_r <= blank_mask;
                end else if (pending_r) begin
                    active_code_r <= shadow_code_r;
                    active_mask_r <= shadow_mask_r;
                end else begin
                    active_code_r <= active_code_r;
                    active_mask_r <= active_mask_r;
                end
            end else begin
                pending_r     <= pending_r | load;
                active_code_r <= active_code_r;
                active_mask_r <= active_mask_r;
            end
        end
    end

    // Registered display outputs, one cycle behind the index/active data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnd_seg_r <= SEG_OFF;
            fnd_com_r <= COM_OFF;
        end else begin
            fnd_seg_r <= next_seg_s;
            fnd_com_r <= next_com_s;
        end
    end

    assign fnd_seg    = fnd_seg_r;
    assign fnd_com    = fnd_com_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_driver
//   Directed bench for fnd_scan_driver with NUM_DIGITS=4, CLK_DIV=4.
//   Two instances share the stimulus: one with an active-high segment bus and
//   one with SEG_ACTIVE_LOW=1. Outputs are sampled 1 time unit after the
//   rising edge. After rst_n release, edge Ek sees idx=(k/4)%4, presc=k%4,
//   and the outputs after Ek reflect that state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fnd_scan_driver;

`ifdef FND_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] seg_in;
    logic [3:0]  blank_mask;
    logic [7:0]  fnd_seg;
    logic [3:0]  fnd_com;
    logic        pending;
    logic        frame_done;
    logic [7:0]  seg_al;
    logic [3:0]  com_al;
    logic        pending_al;
    logic        frame_done_al;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    fnd_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .seg_in(seg_in),
        .blank_mask(blank_mask), .fnd_seg(fnd_seg), .fnd_com(fnd_com),
        .pending(pending), .frame_done(frame_done)
    );

    fnd_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .load(load), .seg_in(seg_in),
        .blank_mask(blank_mask), .fnd_seg(seg_al), .fnd_com(com_al),
        .pending(pending_al), .frame_done(frame_done_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses of the main instance.
    always @(negedge clk) begin
        if (rst_n && frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        seg_in     = 32'h0;
        blank_mask = 4'b0000;

        // 1: reset state and scan order
        repeat (3) @(posedge clk);
        #1;
        check("rst_com",     32'(fnd_com),    32'h0000000F);
        check("rst_seg",     32'(fnd_seg),    32'h00000000);
        check("rst_seg_al",  32'(seg_al),     32'h000000FF);
        check("rst_pending", 32'(pending),    32'h0);
        check("rst_fdone",   32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clk_n(1);                                         // after E0
        check("first_com", 32'(fnd_com), DT ? 32'hF : 32'hE);
        clk_n(1);                                         // after E1
        check("d0_com", 32'(fnd_com), 32'hE);
        check("d0_seg", 32'(fnd_seg), 32'h00);
        clk_n(3);                                         // after E4
        check("slot1_start_com", 32'(fnd_com), DT ? 32'hF : 32'hD);
        clk_n(1);                                         // after E5
        check("d1_com", 32'(fnd_com), 32'hD);

        // 2: mid-frame load held in shadow until the boundary
        seg_in = 32'h4F5B063F;
        load   = 1'b1;
        clk_n(1);                                         // after E6
        load = 1'b0;
        check("load_pending", 32'(pending), 32'h1);
        clk_n(3);                                         // after E9
        check("d2_com",         32'(fnd_com), 32'hB);
        check("d2_seg_old",     32'(fnd_seg), 32'h00);
        check("pending_held",   32'(pending), 32'h1);
        clk_n(6);                                         // after E15 (boundary)
        check("bnd_fdone",   32'(frame_done), 32'h1);
        check("bnd_pending", 32'(pending),    32'h0);
        check("d3_com",      32'(fnd_com),    32'h7);
        check("d3_seg_old",  32'(fnd_seg),    32'h00);
        clk_n(1);                                         // after E16
        check("fdone_clear", 32'(frame_done), 32'h0);
        clk_n(1);                                         // after E17
        check("new_d0_com",    32'(fnd_com), 32'hE);
        check("new_d0_seg",    32'(fnd_seg), 32'h3F);
        check("new_d0_seg_al", 32'(seg_al),  32'hC0);
        clk_n(4);                                         // after E21
        check("new_d1_seg", 32'(fnd_seg), 32'h06);
        clk_n(4);                                         // after E25
        check("new_d2_seg", 32'(fnd_seg), 32'h5B);
        clk_n(4);                                         // after E29
        check("new_d3_com", 32'(fnd_com), 32'h7);
        check("new_d3_seg", 32'(fnd_seg), 32'h4F);
        check("fdone_cnt1", 32'(fd_cnt),  32'd1);

        // 3: two loads in one frame, last one wins
        clk_n(4);                                         // after E33
        seg_in = 32'h11111111;
        load   = 1'b1;
        clk_n(1);                                         // after E34
        load = 1'b0;
        clk_n(4);                                         // after E38
        seg_in = 32'h22222222;
        load   = 1'b1;
        clk_n(1);                                         // after E39
        load = 1'b0;
        check("two_ld_pending", 32'(pending), 32'h1);
        check("two_ld_old_seg", 32'(fnd_seg), 32'h06);
        clk_n(10);                                        // after E49
        check("two_ld_d0", 32'(fnd_seg), 32'h22);
        check("fdone_cnt3", 32'(fd_cnt), 32'd3);
        clk_n(8);                                         // after E57
        check("two_ld_d2_com", 32'(fnd_com), 32'hB);
        check("two_ld_d2",     32'(fnd_seg), 32'h22);

        // 4: load exactly on the boundary cycle goes straight to active
        clk_n(5);                                         // after E62
        seg_in = 32'h66666666;
        load   = 1'b1;
        clk_n(1);                                         // after E63
        load = 1'b0;
        check("bld_fdone",   32'(frame_done), 32'h1);
        check("bld_pending", 32'(pending),    32'h0);
        clk_n(2);                                         // after E65
        check("bld_d0_com", 32'(fnd_com), 32'hE);
        check("bld_d0_seg", 32'(fnd_seg), 32'h66);
        check("bld_pending_after", 32'(pending), 32'h0);

        // 5: blanking, both bus polarities
        seg_in     = 32'h4F5B063F;
        blank_mask = 4'b1010;
        load       = 1'b1;
        clk_n(1);                                         // after E66
        load = 1'b0;
        clk_n(15);                                        // after E81
        check("blk_d0_com",    32'(fnd_com), 32'hE);
        check("blk_d0_seg",    32'(fnd_seg), 32'h3F);
        check("blk_d0_seg_al", 32'(seg_al),  32'hC0);
        clk_n(4);                                         // after E85
        check("blk_d1_com",    32'(fnd_com), 32'hF);
        check("blk_d1_seg",    32'(fnd_seg), 32'h00);
        check("blk_d1_seg_al", 32'(seg_al),  32'hFF);
        check("blk_d1_com_al", 32'(com_al),  32'hF);
        clk_n(4);                                         // after E89
        check("blk_d2_com",    32'(fnd_com), 32'hB);
        check("blk_d2_seg_al", 32'(seg_al),  32'hA4);
        clk_n(4);                                         // after E93
        check("blk_d3_com",    32'(fnd_com), 32'hF);
        check("blk_d3_seg",    32'(fnd_seg), 32'h00);

        // 6: reset mid-slot discards pending data immediately
        seg_in     = 32'h77777777;
        blank_mask = 4'b0000;
        load       = 1'b1;
        clk_n(1);                                         // after E94
        load = 1'b0;
        check("pre_rst_pending", 32'(pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_com",     32'(fnd_com), 32'hF);
        check("mid_rst_seg",     32'(fnd_seg), 32'h00);
        check("mid_rst_seg_al",  32'(seg_al),  32'hFF);
        check("mid_rst_pending", 32'(pending), 32'h0);
        clk_n(2);
        @(negedge clk);
        rst_n = 1'b1;
        clk_n(2);                                         // after E1
        check("post_rst_com",     32'(fnd_com), 32'hE);
        check("post_rst_seg",     32'(fnd_seg), 32'h00);
        check("post_rst_pending", 32'(pending), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
